// File: rtl/ps_pkg.sv
// ps_pkg: shared select encoding and address/depth helpers for program_sequencer_stack
package ps_pkg;
  localparam int MAX_W = 32;
  typedef enum logic [2:0] {SEL_HOLD, SEL_RET, SEL_CALL, SEL_JMP, SEL_JNZ, SEL_LOOP, SEL_INC} next_sel_e;
  function automatic logic [MAX_W-1:0] inc_addr(input logic [MAX_W-1:0] a);
    return a + MAX_W'(1);
  endfunction
  function automatic int depth_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/return_stack.sv
// return_stack: parametrised LIFO of return addresses, depth pointer async-reset active-low
module return_stack import ps_pkg::*; #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int DW = depth_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);
  // storage sized to the pointer range so indexing needs no width adaptation
  logic [W-1:0] mem [2**DW];
  logic [DW-1:0] top_idx;
  assign full = depth == DW'(DEPTH);
  assign empty = depth == '0;
  assign top_idx = depth - DW'(1);
  assign top = empty ? '0 : mem[top_idx];
  always_ff @(posedge clk or negedge reset)
    if (!reset) depth <= '0;
    else if (push && !full) depth <= depth + DW'(1);
    else if (pop && !empty) depth <= depth - DW'(1);
  always_ff @(posedge clk)
    if (push && !full) mem[depth] <= din;
endmodule

// File: rtl/program_sequencer_stack.sv
// program_sequencer_stack: program-memory address sequencer with return stack and hold.
// Optional hardware loop registers enabled by defining PS_HW_LOOP_EN.
module program_sequencer_stack import ps_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  localparam int DEPTH_W = depth_w(STACK_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               jmp,
  input  logic               jmp_nz,
  input  logic               dont_jmp,
  input  logic               call,
  input  logic               ret,
  input  logic [ADDR_W-1:0]  jmp_addr,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic               stack_overflow,
  output logic               stack_underflow
`ifdef PS_HW_LOOP_EN
  ,
  input  logic               loop_start,
  input  logic [ADDR_W-1:0]  loop_count,
  output logic               loop_active
`endif
);
  next_sel_e sel;
  logic [ADDR_W-1:0] pc_inc, stk_top, nxt, loop_tgt;
  logic full, empty, push, pop, loop_ld, loop_jump;
  assign pc_inc = ADDR_W'(inc_addr(MAX_W'(pc)));
`ifdef PS_HW_LOOP_EN
  logic [ADDR_W-1:0] loop_top, loop_end, loop_cnt;
  logic loop_hit;
  assign loop_ld = !hold && loop_start;
  assign loop_hit = loop_active && pc == loop_end && !(hold || loop_start || ret || call || jmp || (jmp_nz && !dont_jmp));
  assign loop_jump = loop_hit && loop_cnt != '0;
  assign loop_tgt = loop_top;
  always_ff @(posedge clk or negedge reset)
    if (!reset) loop_active <= 1'b0;
    else if (loop_ld) loop_active <= 1'b1;
    else if (loop_hit && loop_cnt == '0) loop_active <= 1'b0;
  always_ff @(posedge clk)
    if (loop_ld) begin
      loop_top <= pc_inc;
      loop_end <= jmp_addr;
      loop_cnt <= loop_count;
    end else if (loop_jump) loop_cnt <= loop_cnt - ADDR_W'(1);
`else
  assign loop_ld = 1'b0;
  assign loop_jump = 1'b0;
  assign loop_tgt = '0;
`endif
  always_comb begin
    sel = hold ? SEL_HOLD : loop_ld ? SEL_INC : ret ? SEL_RET : call ? SEL_CALL : jmp ? SEL_JMP :
          (jmp_nz && !dont_jmp) ? SEL_JNZ : loop_jump ? SEL_LOOP : SEL_INC;
    nxt = sel == SEL_HOLD ? pc :
          sel == SEL_RET ? (empty ? pc_inc : stk_top) :
          (sel == SEL_CALL || sel == SEL_JMP || sel == SEL_JNZ) ? jmp_addr :
          sel == SEL_LOOP ? loop_tgt : pc_inc;
  end
  assign pm_addr = !reset ? RESET_ADDR : nxt;
  assign push = sel == SEL_CALL && !full;
  assign pop = sel == SEL_RET && !empty;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= RESET_ADDR;
      stack_overflow <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      pc <= nxt;
      stack_overflow <= stack_overflow || (sel == SEL_CALL && full);
      stack_underflow <= stack_underflow || (sel == SEL_RET && empty);
    end
  return_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(pc_inc),
    .top(stk_top), .full(full), .empty(empty), .depth(stack_depth)
  );
endmodule

// File: tb/tb_program_sequencer_stack.sv
// tb_program_sequencer_stack: directed table, corner sequences and randomized run against a queue-based model
module tb_program_sequencer_stack;
  localparam logic [5:0] H = 6'b100000, J = 6'b010000, N = 6'b001000, D = 6'b000100, C = 6'b000010, R = 6'b000001;
  logic clk = 0, reset = 0, hold = 0, jmp = 0, jmp_nz = 0, dont_jmp = 0, call = 0, ret = 0, loop_start = 0;
  logic [7:0] jmp_addr = 0, loop_count = 0, pm_addr, pc;
  logic [1:0] stack_depth;
  logic stack_overflow, stack_underflow, loop_active;
  int checks = 0, errors = 0;
  int pc_m = 0, lt_m = 0, le_m = 0, lc_m = 0, dummy;
  int q[$];
  bit ovf_m = 0, udf_m = 0, la_m = 0;
  typedef struct { logic [5:0] st; logic [7:0] addr; int pm, pcv, d; bit ov, un; } vec_t;
  vec_t tbl[22];
  always #5 clk = ~clk;
  program_sequencer_stack #(.ADDR_W(8), .STACK_DEPTH(2), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .hold(hold), .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp),
    .call(call), .ret(ret), .jmp_addr(jmp_addr), .pm_addr(pm_addr), .pc(pc),
    .stack_depth(stack_depth), .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
`ifdef PS_HW_LOOP_EN
    , .loop_start(loop_start), .loop_count(loop_count), .loop_active(loop_active)
`endif
  );
`ifndef PS_HW_LOOP_EN
  assign loop_active = 1'b0;
`endif
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  function automatic int exp_pm();
    int inc = (pc_m + 1) % 256;
    if (hold) return pc_m;
    if (loop_start) return inc;
    if (ret) return q.size() > 0 ? q[$] : inc;
    if (call || jmp || (jmp_nz && !dont_jmp)) return int'(jmp_addr);
    if (la_m && pc_m == le_m) return lc_m != 0 ? lt_m : inc;
    return inc;
  endfunction
  task automatic m_step();
    int e = exp_pm();
    int inc = (pc_m + 1) % 256;
    if (!hold) begin
      if (loop_start) begin
        lt_m = inc; le_m = int'(jmp_addr); lc_m = int'(loop_count); la_m = 1;
      end else if (ret) begin
        if (q.size() > 0) void'(q.pop_back()); else udf_m = 1;
      end else if (call) begin
        if (q.size() < 2) q.push_back(inc); else ovf_m = 1;
      end else if (!(jmp || (jmp_nz && !dont_jmp)) && la_m && pc_m == le_m) begin
        if (lc_m != 0) lc_m--; else la_m = 0;
      end
    end
    pc_m = e;
  endtask
  task automatic m_reset();
    pc_m = 0; q.delete(); ovf_m = 0; udf_m = 0; la_m = 0;
  endtask
  task automatic cyc(input logic [5:0] st, input logic [7:0] a, output int pm_seen);
    {hold, jmp, jmp_nz, dont_jmp, call, ret} = st;
    jmp_addr = a;
    #1;
    pm_seen = int'(pm_addr);
    chk("pm_addr", int'(pm_addr), exp_pm());
    @(posedge clk);
    m_step();
    #1;
    chk("pc", int'(pc), pc_m);
    chk("depth", int'(stack_depth), q.size());
    chk("overflow", int'(stack_overflow), int'(ovf_m));
    chk("underflow", int'(stack_underflow), int'(udf_m));
    chk("loop_active", int'(loop_active), int'(la_m));
    @(negedge clk);
  endtask
  task automatic idle_inputs();
    {hold, jmp, jmp_nz, dont_jmp, call, ret} = 6'b0;
    loop_start = 0;
  endtask
  initial begin
    tbl = '{
      '{6'b0, 8'h00, 'h01, 'h01, 0, 0, 0}, '{6'b0, 8'h00, 'h02, 'h02, 0, 0, 0},
      '{6'b0, 8'h00, 'h03, 'h03, 0, 0, 0}, '{J, 8'h05, 'h05, 'h05, 0, 0, 0},
      '{J, 8'h20, 'h20, 'h20, 0, 0, 0}, '{N|D, 8'h50, 'h21, 'h21, 0, 0, 0},
      '{N, 8'h10, 'h10, 'h10, 0, 0, 0}, '{C, 8'h40, 'h40, 'h40, 1, 0, 0},
      '{6'b0, 8'h00, 'h41, 'h41, 1, 0, 0}, '{6'b0, 8'h00, 'h42, 'h42, 1, 0, 0},
      '{R, 8'h00, 'h11, 'h11, 0, 0, 0}, '{C, 8'h60, 'h60, 'h60, 1, 0, 0},
      '{C, 8'h70, 'h70, 'h70, 2, 0, 0}, '{C, 8'h80, 'h80, 'h80, 2, 1, 0},
      '{R, 8'h00, 'h61, 'h61, 1, 1, 0}, '{R, 8'h00, 'h12, 'h12, 0, 1, 0},
      '{R, 8'h00, 'h13, 'h13, 0, 1, 1}, '{J, 8'hFF, 'hFF, 'hFF, 0, 1, 1},
      '{6'b0, 8'h00, 'h00, 'h00, 0, 1, 1}, '{H|J, 8'h33, 'h00, 'h00, 0, 1, 1},
      '{H|J, 8'h33, 'h00, 'h00, 0, 1, 1}, '{H|C, 8'h33, 'h00, 'h00, 0, 1, 1}
    };
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_pm", int'(pm_addr), 0);
      chk("rst_pc", int'(pc), 0);
      chk("rst_depth", int'(stack_depth), 0);
    end
    chk("rst_flags", int'({stack_overflow, stack_underflow, loop_active}), 0);
    reset = 1;
    m_reset();
    foreach (tbl[i]) begin
      int pm_seen;
      cyc(tbl[i].st, tbl[i].addr, pm_seen);
      chk($sformatf("tbl%0d_pm", i), pm_seen, tbl[i].pm);
      chk($sformatf("tbl%0d_pc", i), int'(pc), tbl[i].pcv);
      chk($sformatf("tbl%0d_depth", i), int'(stack_depth), tbl[i].d);
      chk($sformatf("tbl%0d_ovf", i), int'(stack_overflow), int'(tbl[i].ov));
      chk($sformatf("tbl%0d_udf", i), int'(stack_underflow), int'(tbl[i].un));
    end
    #2 reset = 0;
    #1;
    chk("async_pm", int'(pm_addr), 0);
    chk("async_pc", int'(pc), 0);
    chk("async_flags", int'({stack_overflow, stack_underflow}), 0);
    @(negedge clk);
    reset = 1;
    m_reset();
    cyc(H|R, 8'h00, dummy);
    chk("hold_ret_udf", int'(stack_underflow), 0);
    cyc(C, 8'h30, dummy);
    chk("call_depth", int'(stack_depth), 1);
    cyc(C|R, 8'h50, dummy);
    chk("ret_wins_pm", dummy, 'h01);
    chk("ret_wins_depth", int'(stack_depth), 0);
    cyc(C, 8'h44, dummy);
    call = 1;
    jmp_addr = 8'h55;
    #2 reset = 0;
    #1;
    chk("midcall_depth", int'(stack_depth), 0);
    chk("midcall_pc", int'(pc), 0);
    chk("midcall_pm", int'(pm_addr), 0);
    @(negedge clk);
    idle_inputs();
    reset = 1;
    m_reset();
`ifdef PS_HW_LOOP_EN
    begin
      int exp_pcs[6] = '{'h0A, 'h09, 'h0A, 'h09, 'h0A, 'h0B};
      cyc(J, 8'h08, dummy);
      loop_start = 1;
      loop_count = 8'd2;
      cyc(6'b0, 8'h0A, dummy);
      loop_start = 0;
      chk("loop_start_pc", int'(pc), 'h09);
      foreach (exp_pcs[i]) begin
        cyc(6'b0, 8'h00, dummy);
        chk($sformatf("loop_pc%0d", i), int'(pc), exp_pcs[i]);
      end
      chk("loop_done", int'(loop_active), 0);
    end
`endif
    for (int i = 0; i < 600; i++) begin
      logic [5:0] st;
      logic [7:0] a;
      st[5] = $urandom_range(0, 7) == 0;
      st[4] = $urandom_range(0, 5) == 0;
      st[3] = $urandom_range(0, 5) == 0;
      st[2] = $urandom_range(0, 1) == 1;
      st[1] = $urandom_range(0, 5) == 0;
      st[0] = $urandom_range(0, 5) == 0;
      a = 8'($urandom);
`ifdef PS_HW_LOOP_EN
      loop_start = $urandom_range(0, 19) == 0;
      loop_count = 8'($urandom_range(0, 3));
      if (loop_start) a = 8'((pc_m + $urandom_range(1, 4)) % 256);
`endif
      cyc(st, a, dummy);
    end
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_sequencer_stack.md
Name: program_sequencer_stack

Overview:
- Parametrised successor to the 8-bit program sequencer in the microprocessor core.
- Generates the program-memory address each cycle, with configurable address width.
- Adds a hardware return-address stack (CALL/RET) and a pipeline hold input.
- Sits between instruction_decoder (control strobes, jump target) and program_memory (clocked on ~clk, address = pm_addr).

Parameters:
ADDR_W, 8, width of pc/pm_addr/jmp_addr; program space 2^ADDR_W words
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_ADDR, 0, address presented and loaded into pc during reset

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
hold  input  1  freeze sequencer (pm_addr = pc, no stack change)
jmp  input  1  unconditional jump strobe from decoder
jmp_nz  input  1  conditional jump strobe
dont_jmp  input  1  zero_flag from computational unit; suppresses jmp_nz when 1
call  input  1  push return address, jump to jmp_addr
ret  input  1  pop return address into pm_addr
jmp_addr  input  ADDR_W  jump/call target
pm_addr  output  ADDR_W  combinational next address to program_memory
pc  output  ADDR_W  registered current address
stack_depth  output  $clog2(STACK_DEPTH+1)  entries currently held
stack_overflow  output  1  sticky: push attempted while full
stack_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, low): pc = RESET_ADDR; pm_addr = RESET_ADDR while reset is low; stack_depth = 0; both flags 0; stack contents don't-care.
- Each rising clk: pc <= pm_addr. Memory address to data latency is one half-cycle (memory clocked on ~clk); instruction register latency is the decoder's concern.
- pm_addr selection, highest priority first:
  - hold: pc.
  - ret: if depth > 0, top of stack; else pc+1 and set underflow.
  - call: jmp_addr; if depth < STACK_DEPTH, push pc+1; else no push and set overflow.
  - jmp: jmp_addr.
  - jmp_nz and !dont_jmp: jmp_addr.
  - otherwise: pc+1.
- pc+1 wraps modulo 2^ADDR_W (all-ones -> 0). A pushed return address wraps the same way.
- Stack is LIFO, registered on clk. Push/pop and the depth update happen in the same edge as the pc load.
- call and ret in the same cycle: ret wins (the decoder never emits this; behaviour is defined for robustness). Strobes under hold are ignored entirely.
- Overflow/underflow flags: sticky until reset. Flag setting is suppressed under hold.
- Reset asserted mid-call: the stack is emptied and execution restarts at RESET_ADDR.

Optional Feature:
Macro PS_HW_LOOP_EN.
- Defined: adds ports loop_start (in 1), loop_count (in ADDR_W), loop_active (out 1), and a loop register set {top, end, count}.
  - loop_start (priority just below hold): top <= pc+1, end <= jmp_addr, count <= loop_count, pm_addr = pc+1.
  - While active, with no higher-priority strobe and pc == end:
    - count != 0: pm_addr = top, count decrements.
    - count == 0: pm_addr = pc+1, loop_active clears.
  - Nested loop_start reloads the registers.
  - Reset clears loop_active.
- Undefined: none of these ports or registers exist; behaviour is identical to the base block.

Decomposition:
- Package ps_pkg:
  - enum next_sel_e {SEL_HOLD, SEL_RET, SEL_CALL, SEL_JMP, SEL_JNZ, SEL_LOOP, SEL_INC}
  - function inc_addr (wrapping +1)
  - localparam DEPTH_W
- One sub-module, return_stack: parametrised LIFO with push/pop/full/empty/top, async active-low reset of the depth pointer.
- The priority mux and pc register stay in program_sequencer_stack.

Test Plan:
- Reset low for 3 cycles then high, no strobes, ADDR_W=8 -> pm_addr 0 during reset; pc sequence 0,1,2,3 after release.
- pc=0x05, jmp with jmp_addr=0x20 -> pm_addr=0x20 that cycle; next pc=0x20. Then jmp_nz with dont_jmp=1 -> pc=0x21.
- pc=0x10: call 0x40 -> depth 1, pc=0x40; at pc=0x42, ret -> pm_addr=0x11, depth 0.
- STACK_DEPTH=2: three nested calls -> third still jumps, overflow=1, depth stays 2. Two rets return to the first two return addresses; a third ret -> pm_addr=pc+1, underflow=1.
- pc=0xFF, no strobe -> pc=0x00. Then hold=1 with jmp for 2 cycles -> pc stays 0x00, depth unchanged.
- PS_HW_LOOP_EN, pc=0x08: loop_start, loop_count=2, jmp_addr=0x0A -> body 0x09..0x0A executes 3 times, then pc=0x0B and loop_active=0.
